// File: rtl/seven_seg_display_ctrl.sv
// Two-digit seven-segment PMOD scheduler: arbitrates requesters A/B once per frame, latches the
// owner's byte and multiplexes both digits with a blank gap. Macro SEV_SEG_BRIGHTNESS_EN adds PWM dimming.
module seven_seg_display_ctrl #(
  parameter int REFRESH_DIV  = 12000,
  parameter int BLANK_CYCLES = 120,
  parameter int HOLD_FRAMES  = 8
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_req_a,
  input  logic [7:0] i_value_a,
  input  logic       i_req_b,
  input  logic [7:0] i_value_b,
`ifdef SEV_SEG_BRIGHTNESS_EN
  input  logic [3:0] i_brightness,
`endif
  output logic       o_grant_a,
  output logic       o_grant_b,
  output logic [6:0] o_sev_segments,
  output logic       o_sev_seg_cathode,
  output logic       o_frame_tick
);

  localparam int MAX_DWELL = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW = $clog2(MAX_DWELL);
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {SHOW0, BLANK0, SHOW1, BLANK1} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [HW-1:0] hold_q, hold_d;
  logic          grantA_q, grantA_d;
  logic          grantB_q, grantB_d;
  logic          lastB_q, lastB_d;
  logic [7:0]    latch_q, latch_d;
  logic [6:0]    seg_q;
  logic          cathode_q;
  logic          tick_q;
  logic          dwellDone;
  logic          boundary;
  logic          dutyOn;
  logic          lit;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign dwellDone = (state_q == SHOW0 || state_q == SHOW1) ? (cnt_q == SHOW_LAST)
                                                            : (cnt_q == BLANK_LAST);
  assign boundary  = (state_q == BLANK1) && dwellDone;
  assign lit       = (grantA_q || grantB_q) && dutyOn;

`ifdef SEV_SEG_BRIGHTNESS_EN
  logic [3:0] bright_q;
  assign dutyOn = (cnt_q[3:0] <= bright_q);
`else
  assign dutyOn = 1'b1;
`endif

  // Frame-boundary arbitration: hold, then hand over, then keep, then round-robin from idle.
  always_comb begin
    grantA_d = 1'b0;
    grantB_d = 1'b0;
    hold_d   = '0;
    if (((grantA_q && i_req_a) || (grantB_q && i_req_b)) && (hold_q < HOLD_LAST)) begin
      grantA_d = grantA_q;
      grantB_d = grantB_q;
      hold_d   = hold_q + HW'(1);
    end else if (grantA_q && i_req_b) begin
      grantB_d = 1'b1;
    end else if (grantB_q && i_req_a) begin
      grantA_d = 1'b1;
    end else if (grantA_q && i_req_a) begin
      grantA_d = 1'b1;
    end else if (grantB_q && i_req_b) begin
      grantB_d = 1'b1;
    end else if (!grantA_q && !grantB_q) begin
      if (i_req_a && i_req_b) begin
        grantA_d = lastB_q;
        grantB_d = !lastB_q;
      end else begin
        grantA_d = i_req_a;
        grantB_d = i_req_b;
      end
    end
    lastB_d = grantB_d ? 1'b1 : (grantA_d ? 1'b0 : lastB_q);
    latch_d = grantA_d ? i_value_a : (grantB_d ? i_value_b : latch_q);
  end

  // Output registers follow the state one cycle late, so each state's outputs last its full dwell.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= SHOW0;
      cnt_q     <= '0;
      hold_q    <= '0;
      grantA_q  <= 1'b0;
      grantB_q  <= 1'b0;
      lastB_q   <= 1'b1;
      latch_q   <= 8'h00;
      seg_q     <= 7'h7F;
      cathode_q <= 1'b0;
      tick_q    <= 1'b0;
`ifdef SEV_SEG_BRIGHTNESS_EN
      bright_q  <= 4'hF;
`endif
    end else begin
      tick_q <= boundary;
      case (state_q)
        SHOW0: begin
          cathode_q <= 1'b1;
          seg_q     <= lit ? ~decode(latch_q[3:0]) : 7'h7F;
        end
        SHOW1: begin
          cathode_q <= 1'b0;
          seg_q     <= lit ? ~decode(latch_q[7:4]) : 7'h7F;
        end
        default: seg_q <= 7'h7F;
      endcase
      if (dwellDone) begin
        cnt_q <= '0;
        case (state_q)
          SHOW0:   state_q <= BLANK0;
          BLANK0:  state_q <= SHOW1;
          SHOW1:   state_q <= BLANK1;
          default: state_q <= SHOW0;
        endcase
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (boundary) begin
        grantA_q <= grantA_d;
        grantB_q <= grantB_d;
        hold_q   <= hold_d;
        lastB_q  <= lastB_d;
        latch_q  <= latch_d;
`ifdef SEV_SEG_BRIGHTNESS_EN
        bright_q <= i_brightness;
`endif
      end
    end
  end

  assign o_grant_a         = grantA_q;
  assign o_grant_b         = grantB_q;
  assign o_sev_segments    = seg_q;
  assign o_sev_seg_cathode = cathode_q;
  assign o_frame_tick      = tick_q;

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Self-checking bench for seven_seg_display_ctrl: frame-position reference model, per-cycle compare,
// directed literal checks and randomized requester traffic. Honours SEV_SEG_BRIGHTNESS_EN when defined.
module tb_seven_seg_display_ctrl;
  localparam int RD    = 16;
  localparam int BC    = 2;
  localparam int HF    = 2;
  localparam int FRAME = 2 * (RD + BC);

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       reqA  = 1'b0;
  logic       reqB  = 1'b0;
  logic [7:0] valA  = 8'h00;
  logic [7:0] valB  = 8'h00;
`ifdef SEV_SEG_BRIGHTNESS_EN
  logic [3:0] bright = 4'hF;
`endif
  logic       grantA, grantB, cathode, tick;
  logic [6:0] seg;

  int checkCount = 0;
  int passCount  = 0;

  logic [6:0] segTable [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_seg_display_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .HOLD_FRAMES(HF)) dut (
    .i_clock          (clk),
    .i_reset_n        (rst_n),
    .i_req_a          (reqA),
    .i_value_a        (valA),
    .i_req_b          (reqB),
    .i_value_b        (valB),
`ifdef SEV_SEG_BRIGHTNESS_EN
    .i_brightness     (bright),
`endif
    .o_grant_a        (grantA),
    .o_grant_b        (grantB),
    .o_sev_segments   (seg),
    .o_sev_seg_cathode(cathode),
    .o_frame_tick     (tick)
  );

  always #5 clk = ~clk;

  // Reference model: tracks edges since reset; owner 0 = none, 1 = A, 2 = B.
  int         mEdges, mOwner, mHold, mLast;
  logic [7:0] mLatch;
  logic [3:0] mBright;
  logic [6:0] expSeg;
  logic       expCath, expTick, expGA, expGB;

  task automatic mReset();
    mEdges = 0; mOwner = 0; mHold = 0; mLast = 2; mLatch = 8'h00; mBright = 4'hF;
    expSeg = 7'h7F; expCath = 1'b0; expTick = 1'b0; expGA = 1'b0; expGB = 1'b0;
  endtask

  task automatic mArbitrate();
    bit ownerReq, otherReq, a, b;
    a = reqA; b = reqB;
    ownerReq = (mOwner == 1) ? a : (mOwner == 2) ? b : 1'b0;
    otherReq = (mOwner == 1) ? b : (mOwner == 2) ? a : 1'b0;
    if (mOwner != 0 && ownerReq && mHold < HF - 1) begin
      mHold++;
    end else if (mOwner != 0 && otherReq) begin
      mOwner = 3 - mOwner; mHold = 0;
    end else if (mOwner != 0 && ownerReq) begin
      mHold = 0;
    end else if (mOwner == 0 && (a || b)) begin
      if (a && b) mOwner = 3 - mLast;
      else        mOwner = a ? 1 : 2;
      mHold = 0;
    end else begin
      mOwner = 0; mHold = 0;
    end
    if (mOwner != 0) begin
      mLast  = mOwner;
      mLatch = (mOwner == 1) ? valA : valB;
    end
  endtask

  task automatic mStep();
    int pos, slot, owner0, nib;
    logic [7:0] latch0;
    logic [3:0] bright0;
    bit shown, frameEnd;
    pos = mEdges % FRAME; owner0 = mOwner; latch0 = mLatch; bright0 = mBright;
    mEdges++;
    frameEnd = (mEdges % FRAME) == 0;
    if (frameEnd) begin
      mArbitrate();
`ifdef SEV_SEG_BRIGHTNESS_EN
      mBright = bright;
`endif
    end
    expTick = frameEnd;
    expGA = (mOwner == 1);
    expGB = (mOwner == 2);
    slot = 0; nib = 0; shown = 1'b0;
    if (pos < RD) begin
      expCath = 1'b1; slot = pos; nib = int'(latch0[3:0]); shown = 1'b1;
    end else if (pos >= RD + BC && pos < 2 * RD + BC) begin
      expCath = 1'b0; slot = pos - RD - BC; nib = int'(latch0[7:4]); shown = 1'b1;
    end
    if (shown && owner0 != 0 && (slot % 16) <= int'(bright0)) expSeg = ~segTable[nib];
    else expSeg = 7'h7F;
  endtask

  initial begin
    mReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mReset();
      else mStep();
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, actual, expected, $time);
  endtask

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("segments", 8'(seg), 8'(expSeg));
      checkOutput("cathode", 8'(cathode), 8'(expCath));
      checkOutput("frame_tick", 8'(tick), 8'(expTick));
      checkOutput("grant_a", 8'(grantA), 8'(expGA));
      checkOutput("grant_b", 8'(grantB), 8'(expGB));
      checkOutput("grant_exclusive", 8'(grantA & grantB), 8'h00);
    end
  end

  task automatic applyStimulus(input logic a, input logic [7:0] va, input logic b, input logic [7:0] vb);
    reqA = a; valA = va; reqB = b; valB = vb;
  endtask

  task automatic waitTick(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (tick !== 1'b1 && cycles < 3 * FRAME);
    if (tick !== 1'b1) checkOutput("tick_timeout", 8'h00, 8'h01);
  endtask

  logic rrExpectA [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int cyc;
    $display("[TB] start: frame = %0d cycles", FRAME);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_segments", 8'(seg), 8'h7F);
    checkOutput("reset_cathode", 8'(cathode), 8'h00);
    checkOutput("reset_grants", 8'({grantA, grantB}), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle frames: tick period and blank display
    for (int i = 0; i < 4; i++) begin
      waitTick(cyc);
      checkOutput("idle_tick_period", 8'(cyc), 8'(FRAME));
      checkOutput("idle_grants", 8'({grantA, grantB}), 8'h00);
    end

    // Both requesters rise together while idle: A first, 2 frames each
    applyStimulus(1'b1, 8'hA1, 1'b1, 8'hB2);
    for (int i = 0; i < 5; i++) begin
      waitTick(cyc);
      checkOutput("rr_grant_a", 8'(grantA), 8'(rrExpectA[i]));
      checkOutput("rr_grant_b", 8'(grantB), 8'(!rrExpectA[i]));
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    waitTick(cyc);
    checkOutput("drop_all_grants", 8'({grantA, grantB}), 8'h00);

    // A alone with 8'h3A
    applyStimulus(1'b1, 8'h3A, 1'b0, 8'h00);
    waitTick(cyc);
    checkOutput("a_grant", 8'(grantA), 8'h01);
    @(negedge clk);
    checkOutput("show0_first_3A", 8'(seg), 8'h08);
    checkOutput("show0_cathode", 8'(cathode), 8'h01);
    repeat (15) @(negedge clk);
    checkOutput("show0_last_3A", 8'(seg), 8'h08);
    @(negedge clk);
    checkOutput("blank0_seg", 8'(seg), 8'h7F);
    checkOutput("blank0_cathode_hold", 8'(cathode), 8'h01);
    repeat (2) @(negedge clk);
    checkOutput("show1_first_3A", 8'(seg), 8'h30);
    checkOutput("show1_cathode", 8'(cathode), 8'h00);
    repeat (15) @(negedge clk);
    checkOutput("show1_last_3A", 8'(seg), 8'h30);

    // Mid-frame value change must not tear the frame
    applyStimulus(1'b1, 8'h11, 1'b0, 8'h00);
    waitTick(cyc);
    repeat (5) @(negedge clk);
    applyStimulus(1'b1, 8'h22, 1'b0, 8'h00);
    repeat (5) @(negedge clk);
    checkOutput("no_tear_show0", 8'(seg), 8'h79);
    repeat (10) @(negedge clk);
    checkOutput("no_tear_show1", 8'(seg), 8'h79);
    waitTick(cyc);
    @(negedge clk);
    checkOutput("new_value_22", 8'(seg), 8'h24);

    // A drops during hold 0 with B idle
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 8'h22, 1'b0, 8'h00);
    waitTick(cyc);
    checkOutput("drop_grant_a", 8'(grantA), 8'h00);
    repeat (5) @(negedge clk);
    checkOutput("drop_blank", 8'(seg), 8'h7F);

    // Asynchronous reset in the middle of SHOW1
    applyStimulus(1'b1, 8'h55, 1'b0, 8'h00);
    waitTick(cyc);
    repeat (25) @(negedge clk);
    checkOutput("pre_reset_show1_55", 8'(seg), 8'h12);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_seg", 8'(seg), 8'h7F);
    checkOutput("async_reset_grant", 8'(grantA), 8'h00);
    checkOutput("async_reset_cathode", 8'(cathode), 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitTick(cyc);
    checkOutput("post_reset_first_tick", 8'(cyc), 8'(FRAME));
    checkOutput("post_reset_grant_a", 8'(grantA), 8'h01);

`ifdef SEV_SEG_BRIGHTNESS_EN
    bright = 4'h3;
    applyStimulus(1'b1, 8'h88, 1'b0, 8'h00);
    waitTick(cyc);
    @(negedge clk);
    checkOutput("dim_on_first", 8'(seg), 8'h00);
    repeat (3) @(negedge clk);
    checkOutput("dim_on_last", 8'(seg), 8'h00);
    @(negedge clk);
    checkOutput("dim_off_first", 8'(seg), 8'h7F);
    repeat (11) @(negedge clk);
    checkOutput("dim_off_last", 8'(seg), 8'h7F);
    bright = 4'hF;
`endif

    // Randomized requester traffic, checked every cycle by the model
    for (int i = 0; i < 40 * FRAME; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) reqA = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) reqB = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)  valA = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0)  valB = 8'($urandom_range(0, 255));
`ifdef SEV_SEG_BRIGHTNESS_EN
      if ($urandom_range(0, 29) == 0) bright = 4'($urandom_range(0, 15));
`endif
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
